// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and entry type for the instruction fetch buffer
package fetch_pkg;
  localparam int DATA_WIDTH = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_buffer_if.sv
// instr_fetch_buffer_if: fetch-side push and decode-side pop signals of the fetch buffer
interface instr_fetch_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4
);
  logic                       FetchValid;
  logic [DATA_WIDTH-1:0]      Instr;
  logic [DATA_WIDTH-1:0]      PC;
  logic [DATA_WIDTH-1:0]      PCPlus4;
  logic                       FetchReady;
  logic                       Flush;
  logic                       DecodeReady;
  logic                       DecodeValid;
  logic [DATA_WIDTH-1:0]      InstrD;
  logic [DATA_WIDTH-1:0]      PCD;
  logic [DATA_WIDTH-1:0]      PCPlus4D;
  logic [$clog2(DEPTH):0]     Count;
  modport master (
    output FetchValid, Instr, PC, PCPlus4, Flush, DecodeReady,
    input  FetchReady, DecodeValid, InstrD, PCD, PCPlus4D, Count
  );
  modport slave (
    input  FetchValid, Instr, PC, PCPlus4, Flush, DecodeReady,
    output FetchReady, DecodeValid, InstrD, PCD, PCPlus4D, Count
  );
endinterface

// File: rtl/fetch_buf_mem.sv
// fetch_buf_mem: DEPTH-entry register array, synchronous write, asynchronous read, no reset
module fetch_buf_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  entry_t                   wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output entry_t                   rdata
);
  entry_t mem [DEPTH];
  // write the addressed entry on a push
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: FIFO between fetch and decode with flush; optional same-cycle bypass via FETCH_BUF_BYPASS_EN
module instr_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  instr_fetch_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
  } entry_t;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          empty, bypass, push, pop;
  entry_t        wr_entry, rd_entry;
  assign empty = count == '0;
`ifdef FETCH_BUF_BYPASS_EN
  assign bypass = empty && bus.FetchValid && bus.DecodeReady && !bus.Flush;
`else
  assign bypass = 1'b0;
`endif
  assign bus.FetchReady = count != (PW+1)'(DEPTH);
  // a bypassed instruction is neither stored nor popped
  assign push = bus.FetchValid && bus.FetchReady && !bypass;
  assign pop  = !empty && bus.DecodeReady;
  assign wr_entry = '{instr: bus.Instr, pc: bus.PC, pc_plus4: bus.PCPlus4};
  fetch_buf_mem #(.DEPTH(DEPTH), .entry_t(entry_t)) u_mem (
    .clk   (clk),
    .we    (push && !bus.Flush),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );
  // head mux: bypass input, NOP when empty, otherwise the stored head
  always_comb begin
    bus.DecodeValid = !empty || bypass;
    bus.InstrD      = bypass ? bus.Instr   : empty ? DATA_WIDTH'(NOP_INSTR) : rd_entry.instr;
    bus.PCD         = bypass ? bus.PC      : empty ? '0 : rd_entry.pc;
    bus.PCPlus4D    = bypass ? bus.PCPlus4 : empty ? '0 : rd_entry.pc_plus4;
  end
  assign bus.Count = count;
  // pointer and occupancy update; flush discards everything including this cycle's push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end
endmodule
